// File: rtl/button_debouncer.sv
// Push-button debouncer: polarity fix, 2-flop synchronizer, qualify FSM and stability counter.
// Optional saturating abort counter on GlitchCount when DEBOUNCE_GLITCH_CNT_EN is defined.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16,
  parameter bit          BTN_ACT_LOW   = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       RawButton,
  output logic       Level,
  output logic       Busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] GlitchCount
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  // Polarity is normalised before the synchronizer so s2 always means "pressed".
  always_comb begin
    s1_d = BTN_ACT_LOW ? ~RawButton : RawButton;
    s2_d = s1_q;
  end

  // Qualify FSM: a candidate level must be seen STABLE_CYCLES times in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    // Busy is registered from the next state, so it always equals a decode of state_q.
    busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign Level = level_q;
  assign Busy  = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  // Count aborted qualifications, saturating at 8'hFF.
  always_comb begin
    glitch_d = glitch_q;
    if (((state_q == ST_WAIT_HIGH) && !s2_q) || ((state_q == ST_WAIT_LOW) && s2_q)) begin
      if (glitch_q != 8'hFF) begin
        glitch_d = glitch_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign GlitchCount = glitch_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_CYCLES=4, active-low button).
// Directed scenarios plus random bounce checked against a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned SC = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       RawButton;
  logic       Level;
  logic       Busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] GlitchCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pipeline of two samples, then a run length of samples that disagree with Level.
  bit m_s1, m_s2, m_level;
  int m_run;
  int m_glitch;

  button_debouncer #(
    .STABLE_CYCLES(SC),
    .CNT_W(16),
    .BTN_ACT_LOW(1'b1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .RawButton(RawButton),
    .Level(Level),
    .Busy(Busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .GlitchCount(GlitchCount)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic m_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_level = 1'b0;
    m_run = 0;
    m_glitch = 0;
  endtask

  task automatic m_step(input bit pressed);
    if (m_s2 != m_level) begin
      m_run++;
      if (m_run == int'(SC)) begin
        m_level = ~m_level;
        m_run = 0;
      end
    end else begin
      if (m_run != 0 && m_glitch < 255) m_glitch++;
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = pressed;
  endtask

  // Drive one raw value for one clock; returns at the following falling edge.
  task automatic step(input logic raw);
    RawButton = raw;
    @(posedge Clock);
    if (Reset) m_step(~raw);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    RawButton = 1'b0;
    m_reset();
    repeat (3) @(negedge Clock);
    n_checks++;
    if (Level !== 1'b0) begin n_fail++; $display("FAIL reset_level got=%0b exp=0", Level); end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_checks++;
    if (GlitchCount !== 8'd0) begin n_fail++; $display("FAIL reset_glitch got=%0d exp=0", GlitchCount); end
`endif
    Reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      n_checks++;
      if (Level !== (k >= 6)) begin
        n_fail++; $display("FAIL rst_release_level edge=%0d got=%0b exp=%0b", k, Level, (k >= 6));
      end
      n_checks++;
      if (Busy !== (k >= 3 && k <= 5)) begin
        n_fail++; $display("FAIL rst_release_busy edge=%0d got=%0b exp=%0b", k, Busy, (k >= 3 && k <= 5));
      end
    end
  endtask

  task automatic test_release();
    for (int k = 1; k <= 11; k++) begin
      step((k <= 3) ? 1'b1 : 1'b0);
      n_checks++;
      if (Level !== 1'b1) begin n_fail++; $display("FAIL high_blip edge=%0d got=%0b exp=1", k, Level); end
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      n_checks++;
      if (Level !== (k < 6)) begin
        n_fail++; $display("FAIL release_level edge=%0d got=%0b exp=%0b", k, Level, (k < 6));
      end
    end
  endtask

  task automatic test_clean_press();
    int  rises;
    logic prev;
    rises = 0;
    prev = Level;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      if (Level === 1'b1 && prev === 1'b0) rises++;
      prev = Level;
      n_checks++;
      if (Level !== (k >= 6)) begin
        n_fail++; $display("FAIL press_level edge=%0d got=%0b exp=%0b", k, Level, (k >= 6));
      end
    end
    n_checks++;
    if (rises != 1) begin n_fail++; $display("FAIL press_single_edge got=%0d exp=1", rises); end
    repeat (8) step(1'b1);
    n_checks++;
    if (Level !== 1'b0) begin n_fail++; $display("FAIL press_back_low got=%0b exp=0", Level); end
  endtask

  task automatic test_bounce();
    logic seq [15];
    int   g0;
    seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    g0 = m_glitch;
    for (int k = 0; k < 15; k++) begin
      step(seq[k]);
      n_checks++;
      if (Level !== 1'b0) begin n_fail++; $display("FAIL bounce_level edge=%0d got=%0b exp=0", k + 1, Level); end
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL bounce_end_busy got=%0b exp=0", Busy); end
    n_checks++;
    if (m_glitch != g0 + 2) begin n_fail++; $display("FAIL bounce_model_glitch got=%0d exp=%0d", m_glitch, g0 + 2); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_checks++;
    if (GlitchCount !== 8'(g0 + 2)) begin
      n_fail++; $display("FAIL bounce_glitch got=%0d exp=%0d", GlitchCount, g0 + 2);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    repeat (4) step(1'b0);
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy_pre got=%0b exp=1", Busy); end
    Reset = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL midwait_async_busy got=%0b exp=0", Busy); end
    n_checks++;
    if (Level !== 1'b0) begin n_fail++; $display("FAIL midwait_async_level got=%0b exp=0", Level); end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      n_checks++;
      if (Level !== (k >= 6) || Busy !== (k >= 3 && k <= 5)) begin
        n_fail++;
        $display("FAIL midwait_requal edge=%0d level=%0b busy=%0b exp_level=%0b exp_busy=%0b",
                 k, Level, Busy, (k >= 6), (k >= 3 && k <= 5));
      end
    end
    // Asynchronous clear from HIGH, observed between clock edges.
    Reset = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (Level !== 1'b0) begin n_fail++; $display("FAIL high_async_level got=%0b exp=0", Level); end
    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      n_checks++;
      if (Level !== 1'b0) begin n_fail++; $display("FAIL post_reset_released edge=%0d got=%0b exp=0", k, Level); end
    end
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  task automatic test_glitch_saturation();
    int exp_cnt;
    for (int i = 0; i < 300; i++) begin
      step(1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      if (i == 9 || i == 254 || i == 255 || i == 299) begin
        n_checks++;
        if (GlitchCount !== 8'(exp_cnt)) begin
          n_fail++; $display("FAIL glitch_sat aborts=%0d got=%0d exp=%0d", i + 1, GlitchCount, exp_cnt);
        end
      end
    end
    n_checks++;
    if (Level !== 1'b0) begin n_fail++; $display("FAIL glitch_sat_level got=%0b exp=0", Level); end
  endtask
`endif

  task automatic test_random();
    logic raw;
    int   len;
    int   errs;
    errs = 0;
    for (int seg = 0; seg < 400; seg++) begin
      raw = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        step(raw);
        n_checks++;
        if (Level !== m_level || Busy !== (m_run != 0)) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL random seg=%0d level=%0b busy=%0b exp_level=%0b exp_busy=%0b",
                     seg, Level, Busy, m_level, (m_run != 0));
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (GlitchCount !== 8'(m_glitch)) begin
          n_fail++;
          errs++;
          if (errs < 10) $display("FAIL random_glitch seg=%0d got=%0d exp=%0d", seg, GlitchCount, m_glitch);
        end
`endif
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    RawButton = 1'b1;
    m_reset();
    @(negedge Clock);
    test_reset();
    test_release();
    test_clean_press();
    test_bounce();
    test_reset_mid_wait();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    test_glitch_saturation();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
